// File: rtl/gfp8_nv_dot_acc.sv
// GFP8 native-vector dot-product engine: 4-stage pipeline (capture, group dot,
// NV combine, chain accumulate) with valid/ready handshakes on both sides.

module gfp8_nv_group_dot #(
  parameter int GROUP_SIZE = 32,
  parameter int GSUM_W     = 21
) (
  input  logic [GROUP_SIZE*8-1:0] man_l,
  input  logic [GROUP_SIZE*8-1:0] man_r,
  output logic signed [GSUM_W-1:0] gsum
);
  logic signed [15:0] prod;

  always_comb begin
    gsum = '0;
    prod = '0;
    for (int e = 0; e < GROUP_SIZE; e++) begin
      prod = $signed(man_l[e*8 +: 8]) * $signed(man_r[e*8 +: 8]);
      gsum = gsum + GSUM_W'(prod);
    end
  end
endmodule

module gfp8_nv_dot_acc #(
  parameter int NUM_GROUPS = 4,
  parameter int GROUP_SIZE = 32,
  parameter int EXP_BIAS   = 15,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset_n,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  input  logic                                  i_last,
  input  logic [8*NUM_GROUPS-1:0]               i_exp_left,
  input  logic [8*NUM_GROUPS-1:0]               i_exp_right,
  input  logic [8*NUM_GROUPS*GROUP_SIZE-1:0]    i_man_left,
  input  logic [8*NUM_GROUPS*GROUP_SIZE-1:0]    i_man_right,
  output logic                                  o_valid,
  input  logic                                  i_out_ready,
  output logic signed [ACC_WIDTH-1:0]           o_result_mantissa,
  output logic signed [7:0]                     o_result_exponent,
  output logic                                  o_sat
);
  localparam int STAGES = 3;
  localparam int GSUM_W = 16 + $clog2(GROUP_SIZE);
  localparam int NV_W   = GSUM_W + 4;
  localparam int SUM_W  = ((ACC_WIDTH > NV_W) ? ACC_WIDTH : NV_W) + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'sd1 <<< (ACC_WIDTH-1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(64'sd1 <<< (ACC_WIDTH-1)));

  // Alignment shift: distances of 32 or more flush the operand to zero.
  function automatic logic signed [SUM_W-1:0] ashr(input logic signed [SUM_W-1:0] v,
                                                    input logic signed [8:0] d);
    if (d >= 9'sd32) return '0;
    return v >>> d[4:0];
  endfunction

  logic en;
  logic [STAGES:1] vld_pipe, last_pipe;

  assign en      = !(o_valid && !i_out_ready);
  assign o_ready = en;

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else if (en) begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], i_valid};
      last_pipe <= {last_pipe[STAGES-1:1], i_last};
    end

  // S1 capture
  logic [NUM_GROUPS-1:0][4:0] exp_l_in, exp_r_in, s1_exp_l, s1_exp_r;
  logic [8*NUM_GROUPS*GROUP_SIZE-1:0] s1_man_l, s1_man_r;

  always_comb
    for (int g = 0; g < NUM_GROUPS; g++) begin
      exp_l_in[g] = i_exp_left[g*8 +: 5];
      exp_r_in[g] = i_exp_right[g*8 +: 5];
    end

  always_ff @(posedge i_clk)
    if (en && i_valid) begin
      s1_exp_l <= exp_l_in;
      s1_exp_r <= exp_r_in;
      s1_man_l <= i_man_left;
      s1_man_r <= i_man_right;
    end

  // S2 per-group dot products and group exponents
  logic [NUM_GROUPS-1:0][GSUM_W-1:0] gsum_c, s2_gsum;
  logic [NUM_GROUPS-1:0][7:0]        gexp_c, s2_gexp;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    gfp8_nv_group_dot #(.GROUP_SIZE(GROUP_SIZE), .GSUM_W(GSUM_W)) u_dot (
      .man_l (s1_man_l[g*GROUP_SIZE*8 +: GROUP_SIZE*8]),
      .man_r (s1_man_r[g*GROUP_SIZE*8 +: GROUP_SIZE*8]),
      .gsum  (gsum_c[g])
    );
    assign gexp_c[g] = {3'b0, s1_exp_l[g]} + {3'b0, s1_exp_r[g]} - 8'(2*EXP_BIAS);
  end

  always_ff @(posedge i_clk)
    if (en && vld_pipe[1]) begin
      s2_gsum <= gsum_c;
      s2_gexp <= gexp_c;
    end

  // S3 combine; all-zero groups carry no exponent information
  logic                     nv_nz_c, s3_nv_nz;
  logic signed [7:0]        max_e_c, s3_nv_e;
  logic signed [NV_W-1:0]   nv_sum_c, s3_nv_sum, gx;
  logic signed [8:0]        gdiff;

  always_comb begin
    nv_nz_c  = 1'b0;
    max_e_c  = 8'sh80;
    nv_sum_c = '0;
    gx       = '0;
    gdiff    = '0;
    for (int g = 0; g < NUM_GROUPS; g++)
      if (s2_gsum[g] != '0) begin
        if (!nv_nz_c || $signed(s2_gexp[g]) > max_e_c) max_e_c = $signed(s2_gexp[g]);
        nv_nz_c = 1'b1;
      end
    for (int g = 0; g < NUM_GROUPS; g++)
      if (s2_gsum[g] != '0) begin
        gdiff = {max_e_c[7], max_e_c} - {s2_gexp[g][7], s2_gexp[g]};
        gx    = NV_W'($signed(s2_gsum[g]));
        if (gdiff < 9'sd32) nv_sum_c = nv_sum_c + (gx >>> gdiff[4:0]);
      end
    if (!nv_nz_c) max_e_c = '0;
  end

  always_ff @(posedge i_clk)
    if (en && vld_pipe[2]) begin
      s3_nv_nz  <= nv_nz_c;
      s3_nv_e   <= max_e_c;
      s3_nv_sum <= nv_sum_c;
    end

  // S4 accumulate
  logic signed [ACC_WIDTH-1:0] acc_m, new_m, ch_m;
  logic signed [7:0]           acc_e, new_e, ch_e;
  logic                        acc_empty, acc_sat, sat_now, ch_empty, ch_sat;
  logic signed [SUM_W-1:0]     op_a, op_b, sum;

  always_comb begin
    new_e   = (acc_empty || s3_nv_e > acc_e) ? s3_nv_e : acc_e;
    op_a    = acc_empty ? '0 : ashr(SUM_W'(acc_m), {new_e[7], new_e} - {acc_e[7], acc_e});
    op_b    = ashr(SUM_W'(s3_nv_sum), {new_e[7], new_e} - {s3_nv_e[7], s3_nv_e});
    sum     = op_a + op_b;
    sat_now = 1'b0;
    new_m   = sum[ACC_WIDTH-1:0];
    if (sum > SAT_MAX) begin
      new_m   = SAT_MAX[ACC_WIDTH-1:0];
      sat_now = 1'b1;
    end else if (sum < SAT_MIN) begin
      new_m   = SAT_MIN[ACC_WIDTH-1:0];
      sat_now = 1'b1;
    end
    ch_m     = s3_nv_nz ? new_m : acc_m;
    ch_e     = s3_nv_nz ? new_e : acc_e;
    ch_empty = acc_empty && !s3_nv_nz;
    ch_sat   = acc_sat | (s3_nv_nz & sat_now);
  end

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      acc_m             <= '0;
      acc_e             <= '0;
      acc_empty         <= 1'b1;
      acc_sat           <= 1'b0;
      o_valid           <= 1'b0;
      o_result_mantissa <= '0;
      o_result_exponent <= '0;
      o_sat             <= 1'b0;
    end else begin
      if (en && vld_pipe[3] && last_pipe[3]) o_valid <= 1'b1;
      else if (i_out_ready)                  o_valid <= 1'b0;
      if (en && vld_pipe[3]) begin
        if (last_pipe[3]) begin
          // Chain closes: publish and restart empty so the next beat opens a new chain.
          o_result_mantissa <= ch_empty ? '0 : ch_m;
          o_result_exponent <= ch_empty ? '0 : ch_e;
          o_sat             <= ch_sat;
          acc_m             <= '0;
          acc_e             <= '0;
          acc_empty         <= 1'b1;
          acc_sat           <= 1'b0;
        end else if (s3_nv_nz) begin
          acc_m     <= new_m;
          acc_e     <= new_e;
          acc_empty <= 1'b0;
          acc_sat   <= acc_sat | sat_now;
        end
      end
    end
endmodule

// File: doc/gfp8_nv_dot_acc.md
Name: gfp8_nv_dot_acc

Overview:
Parametrised, fully pipelined GFP8 native-vector dot-product engine with valid/ready handshakes and multi-NV accumulation. Each accepted beat is one left/right native-vector pair of NUM_GROUPS groups × GROUP_SIZE signed int8 mantissas, with one 5-bit biased exponent per group per side. Beats are accumulated along the K dimension until a beat tagged i_last, then one GFP result (mantissa, exponent, saturation flag) is emitted. It sits between the BCV controller and the result collector.

Parameters:
NUM_GROUPS, 4, groups per native vector (1..8)
GROUP_SIZE, 32, int8 elements per group (power of 2, 8..64)
EXP_BIAS, 15, bias of the 5-bit group exponent
ACC_WIDTH, 32, accumulator and output mantissa width (16..48)

Ports:
i_clk  in  1  clock
i_reset_n  in  1  async active-low reset
i_valid  in  1  input beat valid
o_ready  out  1  input beat accepted when i_valid && o_ready
i_last  in  1  beat closes the current accumulation chain
i_exp_left  in  8*NUM_GROUPS  group g exponent at [g*8 +: 8]; bits [4:0] used, [7:5] ignored
i_exp_right  in  8*NUM_GROUPS  same packing
i_man_left  in  8*NUM_GROUPS*GROUP_SIZE  element e of group g at [(g*GROUP_SIZE+e)*8 +: 8], signed
i_man_right  in  8*NUM_GROUPS*GROUP_SIZE  same packing
o_valid  out  1  result valid; held until accepted
i_out_ready  in  1  downstream accepts when o_valid && i_out_ready
o_result_mantissa  out  ACC_WIDTH  signed accumulated mantissa
o_result_exponent  out  8  signed exponent
o_sat  out  1  saturation occurred in this chain

Behaviour:
- Reset is asynchronous active-low on i_reset_n; clock is i_clk. Reset clears all stage valids, the accumulator, and the chain state. Outputs after reset: o_valid=0, o_result_mantissa=0, o_result_exponent=0, o_sat=0. o_ready=1 one cycle after reset deassertion.
- Pipeline enable: en = !(o_valid && !i_out_ready). o_ready = en. All stages advance only when en=1, and stage valid bits advance with the data, so bubbles are preserved.
- S1 (capture): on accept, register the exponents, mantissas, and i_last.
- S2 (group dot): per group, gsum = Σ signed(l)*signed(r), computed at full width (16+log2(GROUP_SIZE) bits). Group exponent gexp = exp_l[4:0] + exp_r[4:0] − 2*EXP_BIAS, 8-bit signed.
- S3 (NV combine):
  - max_exp is taken over groups with gsum≠0 only.
  - Each nonzero group is aligned: diff = max_exp − gexp. If diff ≥ 32, the aligned value is 0; otherwise it is gsum >>> diff (arithmetic shift).
  - nv_sum is the sum of the aligned values, at full width.
  - If all groups are zero, the NV is marked empty: nv_sum=0 and it makes no exponent contribution.
- S4 (accumulate): the chain accumulator holds acc_m (ACC_WIDTH), acc_e, acc_empty, and sat.
  - Empty NV: the accumulator is unchanged.
  - acc_empty=1: acc_m = sat(nv_sum), acc_e = nv exponent.
  - Otherwise: e = max(acc_e, nv_e). Both operands are right-shifted by the exponent difference using the same ≥32→0 rule, then added, then saturated to the signed ACC_WIDTH range.
  - Saturation sets sat for the chain.
- On an S4 beat with last=1, the output registers load the chain result and o_valid asserts.
  - An all-empty chain outputs mantissa 0, exponent 0.
  - The accumulator resets to empty in the same cycle, so the next beat starts a new chain with no gap.
- Latency: a beat accepted at edge T0 with i_last=1 and no stall gives o_valid=1 after edge T3.
- Throughput: 1 beat/cycle.
- Output handshake: on o_valid && i_out_ready, o_valid clears unless a new last beat arrives in the same cycle (back-to-back results allowed). Output data are stable while o_valid && !i_out_ready.
- A stall freezes every stage. No beat is dropped or duplicated.
- Reset mid-chain discards all partial sums and in-flight beats.

Test Plan:
- Single beat, defaults, all mantissas 1, all exponents 15, i_last=1 → after 3 edges o_valid=1, mantissa=128, exponent=0, o_sat=0.
- Group 0 left exponent 16, others 15, mantissas all 1, i_last=1 → mantissa=32+3*16=80, exponent=1.
- Three back-to-back beats of the first case, i_last only on the third → exactly one result: mantissa=384, exponent=0. An immediately following single-beat chain → 128, exponent 0, with no gap cycle.
- Group 1 mantissas all −1 (left) × 1 (right) with exponent 30/15 (gexp 15), other groups zero → mantissa −32, exponent 15. A second chain with all mantissas zero → 0, exponent 0.
- ACC_WIDTH=20, all mantissas 127, exponents 15, i_last=1 → mantissa=524287, o_sat=1. The next chain (first-case input) gives o_sat=0.
- Hold i_out_ready=0 with 5 beats streamed → o_ready drops, the result stays stable, and no beat is lost. Assert reset mid-chain, then run the first case → result is exactly 128.
